// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

endpackage

// File: rtl/full_subtractor_structure.sv
// 1-bit full subtractor cell: sub = a - b - bin, bout set when the bit underflows.
module full_subtractor_structure (
  input  logic bin,
  input  logic a,
  input  logic b,
  output logic bout,
  output logic sub
);

  logic axb;

  assign axb  = a ^ b;
  assign sub  = axb ^ bin;
  assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// through a single full subtractor cell with a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             cell_sub;
  logic             cell_bout;
  logic             load;
  logic             shift;
  logic             last;

  full_subtractor_structure u_cell (
    .bin  (borrow),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bout (cell_bout),
    .sub  (cell_sub)
  );

  // The newest bit enters at the MSB; after WIDTH shifts res_nxt is the full result.
  assign res_nxt = {cell_sub, res_sr};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt    <= '0;
        borrow <= 1'b0;
      end else if (shift) begin
        cnt    <= cnt + CNT_W'(1);
        borrow <= cell_bout;
      end
      // Outputs only change on completion so partial results are never visible.
      if (last) begin
        diff <= res_nxt;
        bout <= cell_bout;
      end
    end
  end

  // Operand and partial-result shift registers carry data only; no reset needed.
  always_ff @(posedge clk) begin
    if (load) begin
      a_sr <= a;
      b_sr <= b;
    end else if (shift) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt[WIDTH-1:1];
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) with directed vectors.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_exclusive", int'(busy && done), 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("diff", int'(diff), int'(e.d));
          check("bout", int'(bout), int'(e.bo));
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Issue one operation; start is sampled at the next rising edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] dexp, input logic boexp);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    e.d = dexp;
    e.bo = boexp;
    e.cyc = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait until all expected results have been seen, then let the FSM return to idle.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    int c0;

    // Reset state
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, with BUSY width measured
    issue(8'h05, 8'h03, 8'h02, 1'b0);
    busy_cnt = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, W);
    drain();

    issue(8'h03, 8'h05, 8'hFE, 1'b1);  drain();
    issue(8'h00, 8'h00, 8'h00, 1'b0);  drain();
    issue(8'hFF, 8'hFF, 8'h00, 1'b0);  drain();
    issue(8'h00, 8'h01, 8'hFF, 1'b1);  drain();
    issue(8'h80, 8'h7F, 8'h01, 1'b0);  drain();

    // Busy rejection: a second START during the shift phase is ignored
    issue(8'h10, 8'h01, 8'h0F, 1'b0);
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Reset mid-operation
    issue(8'h20, 8'h30, 8'hF0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_bout", int'(bout), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'h09, 8'h04, 8'h05, 1'b0);  drain();

    // Back-to-back with START held high
    begin
      exp_t e;
      @(negedge clk);
      c0 = cyc;
      a = 8'h0A;
      b = 8'h03;
      start = 1'b1;
      e.d = 8'h07; e.bo = 1'b0; e.cyc = c0 + 1 + W;
      sb.push_back(e);
      @(negedge clk);
      a = 8'h03;
      b = 8'h0A;
      e.d = 8'hF9; e.bo = 1'b1; e.cyc = c0 + 11 + W;
      sb.push_back(e);
      while (cyc < c0 + 20 && cyc < c0 + 100) begin
        @(negedge clk);
        if (cyc > c0 + 1 + W && cyc < c0 + 11 + W)
          check("diff_stable", int'(diff), 8'h07);
      end
      start = 1'b0;
      drain();
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
